// File: rtl/lab4_net_router_output_ctrl.sv
// Output-port control for the lab4 ring router: round-robin arbitration with hold-while-stalled.
// Optional grant statistics enabled by LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN.
module lab4_net_router_output_ctrl #(
  parameter int unsigned p_num_reqs   = 3,
  parameter int unsigned p_stat_nbits = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [p_num_reqs-1:0] reqs,
  output logic [p_num_reqs-1:0] grants,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [1:0]            xbar_sel
`ifdef LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
  ,
  input  logic                                 stat_clear,
  output logic [p_num_reqs*p_stat_nbits-1:0]  stat_grants
`endif
);

  localparam int unsigned IDX_W = 2;

  if (p_num_reqs != 3) begin : g_bad_num_reqs
    $error("lab4_net_router_output_ctrl supports exactly 3 requesters");
  end
  if (p_stat_nbits < 1) begin : g_bad_stat_nbits
    $error("p_stat_nbits must be at least 1");
  end

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                  state, state_next;
  logic [p_num_reqs-1:0]   prio, prio_next;
  logic [IDX_W-1:0]        held_idx, held_next;
  logic [IDX_W-1:0]        prio_idx;
  logic [IDX_W-1:0]        winner;
  logic [p_num_reqs-1:0]   win_oh;
  logic [p_num_reqs-1:0]   held_oh;
  logic                    held_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_ARB;
      prio     <= 3'b001;
      held_idx <= '0;
    end else begin
      state    <= state_next;
      prio     <= prio_next;
      held_idx <= held_next;
    end
  end

  // Circular scan upward from the priority position; winner is 0 when nobody requests.
  always_comb begin
    logic             found;
    logic [IDX_W:0]   pos;
    prio_idx = prio[2] ? 2'd2 : (prio[1] ? 2'd1 : 2'd0);
    winner   = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      pos = 3'(prio_idx) + 3'(k);
      if (pos >= 3'd3) pos = pos - 3'd3;
      if (!found && reqs[pos[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = pos[IDX_W-1:0];
      end
    end
    win_oh   = 3'(1) << winner;
    held_oh  = 3'(1) << held_idx;
    held_req = reqs[held_idx];
  end

  always_comb begin
    state_next = state;
    prio_next  = prio;
    held_next  = held_idx;
    grants     = '0;
    out_val    = 1'b0;
    xbar_sel   = '0;
    if (reset) begin
      unique case (state)
        ST_ARB: begin
          out_val  = |reqs;
          xbar_sel = out_val ? winner : 2'd0;
          grants   = win_oh & {3{out_rdy & out_val}};
          if (out_val && out_rdy) begin
            prio_next = {win_oh[1:0], win_oh[2]};
          end else if (out_val) begin
            state_next = ST_HOLD;
            held_next  = winner;
          end
        end
        ST_HOLD: begin
          // Decision stays locked on held_idx; later arrivals wait.
          xbar_sel = held_idx;
          out_val  = held_req;
          grants   = held_oh & {3{out_rdy & held_req}};
          if (!held_req) begin
            state_next = ST_ARB;
          end else if (out_rdy) begin
            state_next = ST_ARB;
            prio_next  = {held_oh[1:0], held_oh[2]};
          end
        end
        default: state_next = ST_ARB;
      endcase
    end
  end

`ifdef LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
  logic [p_stat_nbits-1:0] stat_cnt [p_num_reqs];

  // Saturating per-requester grant counters; clear wins over a same-cycle grant.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      if (!reset || stat_clear) begin
        stat_cnt[i] <= '0;
      end else if (grants[i] && (stat_cnt[i] != '1)) begin
        stat_cnt[i] <= stat_cnt[i] + p_stat_nbits'(1);
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      stat_grants[i*p_stat_nbits +: p_stat_nbits] = stat_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_lab4_net_router_output_ctrl.sv
// Directed self-checking bench for lab4_net_router_output_ctrl.
module tb_lab4_net_router_output_ctrl;

  localparam int unsigned SNB = 16;

  logic       clk;
  logic       reset;
  logic [2:0] reqs;
  logic [2:0] grants;
  logic       out_val;
  logic       out_rdy;
  logic [1:0] xbar_sel;
`ifdef LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
  logic           stat_clear;
  logic [3*SNB-1:0] stat_grants;
`endif

  int checks = 0;
  int errors = 0;

  lab4_net_router_output_ctrl #(.p_num_reqs(3), .p_stat_nbits(SNB)) dut (
    .clk      (clk),
    .reset    (reset),
    .reqs     (reqs),
    .grants   (grants),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .xbar_sel (xbar_sel)
`ifdef LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
    ,
    .stat_clear  (stat_clear),
    .stat_grants (stat_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, input logic [2:0] r, input logic rdy);
    @(negedge clk);
    reset   = rst;
    reqs    = r;
    out_rdy = rdy;
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] eg, input logic ev, input logic [1:0] es);
    checks++;
    assert (grants === eg) else begin
      errors++;
      $error("FAIL %s grants got %b expected %b", tag, grants, eg);
    end
    checks++;
    assert (out_val === ev) else begin
      errors++;
      $error("FAIL %s out_val got %b expected %b", tag, out_val, ev);
    end
    checks++;
    assert (xbar_sel === es) else begin
      errors++;
      $error("FAIL %s xbar_sel got %0d expected %0d", tag, xbar_sel, es);
    end
    checks++;
    assert ((grants & ~reqs) === 3'b000) else begin
      errors++;
      $error("FAIL %s grant_without_req grants %b reqs %b", tag, grants, reqs);
    end
  endtask

  initial begin
    reset   = 1'b0;
    reqs    = 3'b111;
    out_rdy = 1'b1;
`ifdef LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
    stat_clear = 1'b0;
`endif

    // Reset held low two cycles with everyone requesting
    drive(1'b0, 3'b111, 1'b1); chk("rst0", 3'b000, 1'b0, 2'd0);
    drive(1'b0, 3'b111, 1'b1); chk("rst1", 3'b000, 1'b0, 2'd0);

    // Round-robin rotation with constant full request
    drive(1'b1, 3'b111, 1'b1); chk("rr0", 3'b001, 1'b1, 2'd0);
    drive(1'b1, 3'b111, 1'b1); chk("rr1", 3'b010, 1'b1, 2'd1);
    drive(1'b1, 3'b111, 1'b1); chk("rr2", 3'b100, 1'b1, 2'd2);
    drive(1'b1, 3'b111, 1'b1); chk("rr3", 3'b001, 1'b1, 2'd0);
    drive(1'b1, 3'b111, 1'b1); chk("rr4", 3'b010, 1'b1, 2'd1);
    drive(1'b1, 3'b111, 1'b1); chk("rr5", 3'b100, 1'b1, 2'd2);

    // prio=001, requesters 1 and 2
    drive(1'b1, 3'b110, 1'b1); chk("r110a", 3'b010, 1'b1, 2'd1);
    drive(1'b1, 3'b110, 1'b1); chk("r110b", 3'b100, 1'b1, 2'd2);

    // prio=001: stall on winner 0, later arrivals must wait
    drive(1'b1, 3'b101, 1'b0); chk("stall0", 3'b000, 1'b1, 2'd0);
    drive(1'b1, 3'b101, 1'b0); chk("stall1", 3'b000, 1'b1, 2'd0);
    drive(1'b1, 3'b101, 1'b0); chk("stall2", 3'b000, 1'b1, 2'd0);
    drive(1'b1, 3'b111, 1'b1); chk("hold_rel", 3'b001, 1'b1, 2'd0);
    drive(1'b1, 3'b111, 1'b1); chk("after_hold", 3'b010, 1'b1, 2'd1);

    // prio=100: hold on 2, then requester 2 withdraws
    drive(1'b1, 3'b111, 1'b0); chk("hold2", 3'b000, 1'b1, 2'd2);
    drive(1'b1, 3'b011, 1'b1); chk("withdraw", 3'b000, 1'b0, 2'd2);
    drive(1'b1, 3'b011, 1'b1); chk("post_wd", 3'b001, 1'b1, 2'd0);

    // Idle, prio=010
    drive(1'b1, 3'b000, 1'b1); chk("idle", 3'b000, 1'b0, 2'd0);

    // Hold on 1, reset mid-hold abandons it
    drive(1'b1, 3'b011, 1'b0); chk("hold1", 3'b000, 1'b1, 2'd1);
    drive(1'b0, 3'b011, 1'b1); chk("rst_hold", 3'b000, 1'b0, 2'd0);
    drive(1'b1, 3'b101, 1'b1); chk("post_rst", 3'b001, 1'b1, 2'd0);
    drive(1'b1, 3'b101, 1'b1); chk("post_rst2", 3'b100, 1'b1, 2'd2);

`ifdef LAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
    // Clear, then five grants to requester 1
    stat_clear = 1'b1;
    drive(1'b1, 3'b000, 1'b1);
    stat_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b010, 1'b1); chk("stat_g1", 3'b010, 1'b1, 2'd1);
    end
    drive(1'b1, 3'b000, 1'b1);
    checks++;
    assert (stat_grants[SNB +: SNB] === SNB'(5)) else begin
      errors++;
      $error("FAIL stat_cnt1 got %0d expected 5", stat_grants[SNB +: SNB]);
    end
    // Clear coincident with a grant
    drive(1'b1, 3'b010, 1'b1);
    stat_clear = 1'b1;
    drive(1'b1, 3'b000, 1'b1);
    stat_clear = 1'b0;
    checks++;
    assert (stat_grants === '0) else begin
      errors++;
      $error("FAIL stat_clear got %h expected 0", stat_grants);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
